// File: rtl/bus_terminal_fifo.sv
// bus_terminal_fifo: bus-side endpoint with a host->bus TX FIFO and a bus->host RX FIFO,
// show-ahead outputs, occupancy counts, saturating drop counters and a sticky pop error.
module bus_terminal_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int cnt_w   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     pndng,
    input  logic                     pop,
    output logic [pckg_sz-1:0]       D_pop,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    input  logic                     tx_wr,
    input  logic [pckg_sz-1:0]       tx_data,
    output logic                     tx_full,
    input  logic                     rx_rd,
    output logic [pckg_sz-1:0]       rx_data,
    output logic                     rx_vld,
    output logic [$clog2(depth):0]   tx_cnt,
    output logic [$clog2(depth):0]   rx_cnt,
    output logic [cnt_w-1:0]         tx_drop,
    output logic [cnt_w-1:0]         rx_drop,
    output logic                     pop_err
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

    logic [pckg_sz-1:0] r_tx_mem [depth];
    logic [pckg_sz-1:0] r_rx_mem [depth];
    logic [AW:0]        r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [cnt_w-1:0]   r_tx_drop, r_rx_drop;
    logic               r_pop_err;

    logic w_tx_empty, w_tx_full, w_tx_rd_ok, w_tx_wr_ok, w_tx_drop;
    logic w_rx_empty, w_rx_full, w_rx_rd_ok, w_rx_wr_ok, w_rx_drop;

    // Flags come from pre-edge pointers; a read on a full FIFO frees room for a same-cycle write.
    assign w_tx_empty = r_tx_wp == r_tx_rp;
    assign w_tx_full  = (r_tx_wp ^ r_tx_rp) == FULL_XOR;
    assign w_tx_rd_ok = pop && !w_tx_empty;
    assign w_tx_wr_ok = tx_wr && (!w_tx_full || w_tx_rd_ok);
    assign w_tx_drop  = tx_wr && !w_tx_wr_ok;

    assign w_rx_empty = r_rx_wp == r_rx_rp;
    assign w_rx_full  = (r_rx_wp ^ r_rx_rp) == FULL_XOR;
    assign w_rx_rd_ok = rx_rd && !w_rx_empty;
    assign w_rx_wr_ok = push && (!w_rx_full || w_rx_rd_ok);
    assign w_rx_drop  = push && !w_rx_wr_ok;

    always_ff @(posedge clk) begin
        if (w_tx_wr_ok) r_tx_mem[r_tx_wp[AW-1:0]] <= tx_data;
        if (w_rx_wr_ok) r_rx_mem[r_rx_wp[AW-1:0]] <= D_push;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wp   <= '0;
            r_tx_rp   <= '0;
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_tx_drop <= '0;
            r_rx_drop <= '0;
            r_pop_err <= 1'b0;
        end else begin
            if (w_tx_wr_ok) r_tx_wp <= r_tx_wp + (AW+1)'(1);
            if (w_tx_rd_ok) r_tx_rp <= r_tx_rp + (AW+1)'(1);
            if (w_rx_wr_ok) r_rx_wp <= r_rx_wp + (AW+1)'(1);
            if (w_rx_rd_ok) r_rx_rp <= r_rx_rp + (AW+1)'(1);
            if (w_tx_drop && r_tx_drop != '1) r_tx_drop <= r_tx_drop + cnt_w'(1);
            if (w_rx_drop && r_rx_drop != '1) r_rx_drop <= r_rx_drop + cnt_w'(1);
            if (pop && w_tx_empty) r_pop_err <= 1'b1;
        end
    end

    assign pndng   = !w_tx_empty;
    assign tx_full = w_tx_full;
    assign rx_vld  = !w_rx_empty;
    assign D_pop   = w_tx_empty ? '0 : r_tx_mem[r_tx_rp[AW-1:0]];
    assign rx_data = w_rx_empty ? '0 : r_rx_mem[r_rx_rp[AW-1:0]];
    assign tx_cnt  = r_tx_wp - r_tx_rp;
    assign rx_cnt  = r_rx_wp - r_rx_rp;
    assign tx_drop = r_tx_drop;
    assign rx_drop = r_rx_drop;
    assign pop_err = r_pop_err;
endmodule

// File: tb/tb_bus_terminal_fifo.sv
// tb_bus_terminal_fifo: directed stimulus with queue scoreboards for both FIFO paths.
module tb_bus_terminal_fifo;
    logic        clk = 1'b0;
    logic        reset, pop, push, tx_wr, rx_rd;
    logic [15:0] D_push, tx_data;
    logic        pndng, tx_full, rx_vld, pop_err;
    logic [15:0] D_pop, rx_data;
    logic [3:0]  tx_cnt, rx_cnt;
    logic [7:0]  tx_drop, rx_drop;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic [15:0] exp_w;

    bus_terminal_fifo #(.pckg_sz(16), .depth(8), .cnt_w(8)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .pop(pop), .D_pop(D_pop),
        .push(push), .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data),
        .tx_full(tx_full), .rx_rd(rx_rd), .rx_data(rx_data), .rx_vld(rx_vld),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .tx_drop(tx_drop), .rx_drop(rx_drop),
        .pop_err(pop_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_pndng"}, pndng, 0);
        check({tag, "_tx_full"}, tx_full, 0);
        check({tag, "_rx_vld"}, rx_vld, 0);
        check({tag, "_D_pop"}, D_pop, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_tx_cnt"}, tx_cnt, 0);
        check({tag, "_rx_cnt"}, rx_cnt, 0);
        check({tag, "_tx_drop"}, tx_drop, 0);
        check({tag, "_rx_drop"}, rx_drop, 0);
        check({tag, "_pop_err"}, pop_err, 0);
    endtask

    initial begin
        reset = 1'b1; pop = 0; push = 0; tx_wr = 0; rx_rd = 0; D_push = 0; tx_data = 0;
        tick(); tick();
        reset = 1'b0;
        check_zero_state("reset");
        // TX fill to full
        for (int i = 0; i < 8; i++) begin
            tx_wr = 1; tx_data = 16'hA000 + 16'(i); txq.push_back(tx_data);
            tick();
        end
        tx_wr = 0;
        check("t1_full", tx_full, 1);
        check("t1_cnt", tx_cnt, 8);
        check("t1_pndng", pndng, 1);
        check("t1_head", D_pop, 16'hA000);
        // write while full is dropped
        tx_wr = 1; tx_data = 16'hBEEF;
        tick();
        tx_wr = 0;
        check("t2_drop", tx_drop, 1);
        check("t2_cnt", tx_cnt, 8);
        check("t2_head", D_pop, 16'hA000);
        for (int i = 0; i < 8; i++) begin
            exp_w = txq.pop_front();
            check("t2_pop_data", D_pop, exp_w);
            pop = 1;
            tick();
        end
        pop = 0;
        check("t2_pndng", pndng, 0);
        check("t2_dpop0", D_pop, 0);
        check("t2_cnt0", tx_cnt, 0);
        // pop on empty is sticky error
        check("t3_err_pre", pop_err, 0);
        pop = 1;
        tick();
        pop = 0;
        check("t3_err", pop_err, 1);
        check("t3_cnt", tx_cnt, 0);
        tick();
        check("t3_err_sticky", pop_err, 1);
        tx_wr = 1; pop = 1; tx_data = 16'hC0DE;
        tick();
        tx_wr = 0; pop = 0;
        check("t3_pndng", pndng, 1);
        check("t3_head", D_pop, 16'hC0DE);
        check("t3_cnt1", tx_cnt, 1);
        pop = 1;
        tick();
        pop = 0;
        check("t3_drained", pndng, 0);
        // RX fill, then simultaneous push+read on full
        for (int i = 0; i < 8; i++) begin
            push = 1; D_push = 16'h1111 * 16'(i + 1); rxq.push_back(D_push);
            tick();
        end
        push = 0;
        check("t4_cnt", rx_cnt, 8);
        check("t4_vld", rx_vld, 1);
        check("t4_head", rx_data, 16'h1111);
        push = 1; D_push = 16'h9999; rx_rd = 1;
        exp_w = rxq.pop_front();
        rxq.push_back(16'h9999);
        tick();
        rx_rd = 0;
        D_push = 16'hAAAA;
        check("t4_cnt_rw", rx_cnt, 8);
        check("t4_head_rw", rx_data, 16'h2222);
        check("t4_nodrop", rx_drop, 0);
        tick();
        push = 0;
        check("t4_drop", rx_drop, 1);
        check("t4_cnt_drop", rx_cnt, 8);
        for (int i = 0; i < 8; i++) begin
            exp_w = rxq.pop_front();
            check("t4_rd_data", rx_data, exp_w);
            rx_rd = 1;
            tick();
        end
        check("t4_empty", rx_vld, 0);
        check("t4_data0", rx_data, 0);
        tick();
        rx_rd = 0;
        check("t4_rd_empty", rx_cnt, 0);
        // interleaved traffic wraps the pointers
        for (int i = 0; i < 20; i++) begin
            push = 1; D_push = 16'h5000 + 16'(i);
            rx_rd = (i % 3 != 0) && (rxq.size() > 0);
            if (rx_rd) begin
                exp_w = rxq.pop_front();
                check("t5_data", rx_data, exp_w);
            end
            rxq.push_back(D_push);
            tick();
            check("t5_cnt", rx_cnt, rxq.size());
            check("t5_le8", rx_cnt <= 8, 1);
        end
        push = 0; rx_rd = 0;
        while (rxq.size() > 0) begin
            exp_w = rxq.pop_front();
            check("t5_drain", rx_data, exp_w);
            rx_rd = 1;
            tick();
        end
        rx_rd = 0;
        check("t5_empty", rx_vld, 0);
        // reset in the middle of traffic
        for (int i = 0; i < 5; i++) begin
            tx_wr = 1; tx_data = 16'h7000 + 16'(i);
            push = i < 3; D_push = 16'h6000 + 16'(i);
            tick();
        end
        tx_wr = 0; push = 0;
        check("t6_tx_cnt", tx_cnt, 5);
        check("t6_rx_cnt", rx_cnt, 3);
        reset = 1; tx_wr = 1; tx_data = 16'hDEAD; push = 1; pop = 1;
        tick();
        reset = 0; tx_wr = 0; push = 0; pop = 0;
        txq.delete(); rxq.delete();
        check_zero_state("t6");
        tx_wr = 1; tx_data = 16'h1234;
        tick();
        tx_wr = 0;
        check("t6_post_head", D_pop, 16'h1234);
        check("t6_post_cnt", tx_cnt, 1);
        check("t6_post_full", tx_full, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
